// File: rtl/i2s_tx_gen.sv
// i2s_tx_gen: I2S / left- / right-justified serial transmitter with a one-pair holding buffer
module i2s_tx_gen #(
  parameter int AUDIO_DW = 16,
  parameter int SLOT_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic [1:0]          fmt,
  input  logic                mute,
  input  logic [AUDIO_DW-1:0] left_chan,
  input  logic [AUDIO_DW-1:0] right_chan,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                sclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun
);
  localparam int IW = $clog2(2 * SLOT_W);
  localparam logic [IW-1:0] LAST = IW'(2 * SLOT_W - 1);
  localparam logic [IW-1:0] SW = IW'(SLOT_W);
  localparam logic [IW-1:0] RJ_OFF = IW'(SLOT_W - AUDIO_DW);
  localparam bit EQ = SLOT_W == AUDIO_DW;
  if (SLOT_W < AUDIO_DW || AUDIO_DW < 1) begin : g_bad_params
    $error("i2s_tx_gen: SLOT_W must be >= AUDIO_DW >= 1");
  end
  logic bclk, full, rdy_en, fall, load, cap, ch, i2s, spill, bit_n;
  logic [IW-1:0] bidx, nidx, p, off;
  logic [2*AUDIO_DW-1:0] frame_q, hold_q, ld_data, f;
  logic [AUDIO_DW-1:0] s, sh;
  logic [1:0] fmt_q, fm;
  assign sample_ready = rdy_en & ~full;
  // The bit for the new index is computed from the frame being loaded on the wrap edge
  always_comb begin
    fall    = ce & bclk;
    load    = fall & (bidx == LAST);
    cap     = sample_valid & sample_ready;
    nidx    = (bidx == LAST) ? '0 : bidx + 1'b1;
    ld_data = mute ? '0 : cap ? {left_chan, right_chan} : full ? hold_q : frame_q;
    f       = load ? ld_data : frame_q;
    fm      = load ? fmt : fmt_q;
    ch      = nidx >= SW;
    p       = ch ? nidx - SW : nidx;
    s       = ch ? f[AUDIO_DW-1:0] : f[2*AUDIO_DW-1:AUDIO_DW];
    i2s     = fm[1] == fm[0];
    off     = (fm == 2'd1) ? '0 : (fm == 2'd2) ? RJ_OFF : IW'(1);
    sh      = s << (p - off);
    spill   = ch ? f[AUDIO_DW] : frame_q[0] & (fmt_q[1] == fmt_q[0]) & ~mute;
    bit_n   = (i2s && EQ && p == '0) ? spill : (p >= off) ? sh[AUDIO_DW-1] : 1'b0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      bclk        <= 1'b1;
      sclk        <= 1'b1;
      lrclk       <= 1'b1;
      sdata       <= 1'b0;
      bidx        <= LAST;
      frame_q     <= '0;
      hold_q      <= '0;
      full        <= 1'b0;
      rdy_en      <= 1'b0;
      fmt_q       <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      rdy_en      <= 1'b1;
      sclk        <= bclk;
      frame_start <= load;
      underrun    <= load & ~mute & ~full & ~cap;
      if (load) full <= 1'b0;
      else if (cap) begin
        full   <= 1'b1;
        hold_q <= {left_chan, right_chan};
      end
      if (ce) bclk <= ~bclk;
      if (fall) begin
        bidx  <= nidx;
        lrclk <= ch;
        sdata <= bit_n;
      end
      if (load) begin
        frame_q <= ld_data;
        fmt_q   <= fmt;
      end
    end
endmodule

// File: tb/tb_i2s_tx_gen.sv
// tb_i2s_tx_gen: randomized frame plans checked bit-by-bit against a slot-position reference model
module tb_i2s_tx_gen;
  logic clk = 1'b0, reset = 1'b1, ce = 1'b0, mute = 1'b0;
  logic [1:0] fmt = 2'd0;
  logic [15:0] left_chan = '0, right_chan = '0;
  logic sv[3] = '{1'b0, 1'b0, 1'b0};
  logic rdy_w[3], sclk_w[3], lrclk_w[3], sdata_w[3], fs_w[3], ur_w[3];
  logic psclk[3] = '{1'b1, 1'b1, 1'b1};
  logic [1:0] bits[3][128];
  int nb[3] = '{0, 0, 0};
  int ce_mode = 0, active = 0, n_cmp = 0, n_bad = 0, tick = 0, last_fs = 0;
  logic [15:0] m_l, m_r, p_l, p_r;
  logic [1:0] m_fmt, p_fmt;
  logic m_sp, p_mute, p_offer, p_late, have_prev;

  always #5 clk = ~clk;

  i2s_tx_gen #(.AUDIO_DW(16), .SLOT_W(32)) u0 (.clk(clk), .reset(reset), .ce(ce), .fmt(fmt), .mute(mute),
    .left_chan(left_chan), .right_chan(right_chan), .sample_valid(sv[0]), .sample_ready(rdy_w[0]),
    .sclk(sclk_w[0]), .lrclk(lrclk_w[0]), .sdata(sdata_w[0]), .frame_start(fs_w[0]), .underrun(ur_w[0]));
  i2s_tx_gen #(.AUDIO_DW(16), .SLOT_W(16)) u1 (.clk(clk), .reset(reset), .ce(ce), .fmt(fmt), .mute(mute),
    .left_chan(left_chan), .right_chan(right_chan), .sample_valid(sv[1]), .sample_ready(rdy_w[1]),
    .sclk(sclk_w[1]), .lrclk(lrclk_w[1]), .sdata(sdata_w[1]), .frame_start(fs_w[1]), .underrun(ur_w[1]));
  i2s_tx_gen #(.AUDIO_DW(16), .SLOT_W(24)) u2 (.clk(clk), .reset(reset), .ce(ce), .fmt(fmt), .mute(mute),
    .left_chan(left_chan), .right_chan(right_chan), .sample_valid(sv[2]), .sample_ready(rdy_w[2]),
    .sclk(sclk_w[2]), .lrclk(lrclk_w[2]), .sdata(sdata_w[2]), .frame_start(fs_w[2]), .underrun(ur_w[2]));

  initial forever begin
    @(posedge clk); #3;
    ce = (ce_mode == 1) ? 1'b1 : (ce_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Receiver: a bit is taken once sclk has fallen after the data update, so it is stable
  initial forever begin
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (reset) nb[i] = 0;
      else if (i == active && psclk[i] && !sclk_w[i] && nb[i] < 128) begin
        bits[i][nb[i]] = {lrclk_w[i], sdata_w[i]};
        nb[i]++;
      end
      psclk[i] = sclk_w[i];
    end
  end

  function automatic int swof(int i);
    return (i == 1) ? 16 : (i == 2) ? 24 : 32;
  endfunction

  function automatic logic mbit(int sw, logic [1:0] f, logic [15:0] l, logic [15:0] r, logic sp, int n);
    int p, st, k;
    logic [15:0] s, t;
    p  = n % sw;
    s  = (n >= sw) ? r : l;
    st = (f == 2'd1) ? 0 : (f == 2'd2) ? sw - 16 : 1;
    k  = p - st;
    t  = s << k;
    if (k >= 0 && k < 16) return t[15];
    if (f != 2'd1 && f != 2'd2 && sw == 16 && p == 0) return (n >= sw) ? l[0] : sp;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
    tick++;
  endtask

  task automatic make_plan(input int i, input int k, input int mode);
    p_l     = 16'($urandom);
    p_r     = 16'($urandom);
    p_fmt   = (i == 1) ? 2'(3 * $urandom_range(0, 1)) : 2'($urandom_range(0, 3));
    p_mute  = $urandom_range(0, 4) == 0;
    p_offer = $urandom_range(0, 3) != 0;
    p_late  = 1'b0;
    if (k == 1 || k == 2) begin p_offer = 1'b0; p_mute = 1'b0; p_fmt = m_fmt; end
    if (k == 3) begin p_mute = 1'b1; p_offer = 1'b1; end
    if (k == 4 && mode == 1) begin p_mute = 1'b0; p_offer = 1'b1; p_late = 1'b1; end
  endtask

  task automatic apply_plan(input int i);
    logic took;
    fmt = p_fmt; mute = p_mute; left_chan = p_l; right_chan = p_r;
    if (p_offer && !p_late) begin
      took = 1'b0;
      sv[i] = 1'b1;
      for (int c = 0; c < 50 && !took; c++) begin
        took = rdy_w[i];
        step();
      end
      sv[i] = 1'b0;
      chk("accept", 64'(took), 64'd1);
    end
  endtask

  task automatic check_frame(input int i);
    logic [63:0] gd, gl, ed, el;
    int sw;
    sw = swof(i);
    gd = '0; gl = '0; ed = '0; el = '0;
    chk("frame_len", 64'(nb[i]), 64'(2 * sw));
    for (int n = 0; n < 2 * sw; n++) begin
      gd |= 64'(bits[i][n][0]) << n;
      gl |= 64'(bits[i][n][1]) << n;
      ed |= 64'(mbit(sw, m_fmt, m_l, m_r, m_sp, n)) << n;
      el |= 64'(n >= sw) << n;
    end
    chk("sdata", gd, ed);
    chk("lrclk", gl, el);
  endtask

  task automatic run_seq(input int i, input int nfr, input int mode, input logic [1:0] f0,
                         input logic [15:0] l0, input logic [15:0] r0);
    logic ok;
    int sw;
    sw = swof(i);
    active = i; ce_mode = 0;
    for (int j = 0; j < 3; j++) sv[j] = 1'b0;
    reset = 1'b1;
    step();
    chk("rst_sclk", 64'(sclk_w[i]), 64'd1);
    chk("rst_lrclk", 64'(lrclk_w[i]), 64'd1);
    chk("rst_sdata", 64'(sdata_w[i]), 64'd0);
    chk("rst_ready", 64'(rdy_w[i]), 64'd0);
    chk("rst_fs", 64'(fs_w[i]), 64'd0);
    chk("rst_ur", 64'(ur_w[i]), 64'd0);
    reset = 1'b0;
    m_l = '0; m_r = '0; m_fmt = 2'd0; m_sp = 1'b0; have_prev = 1'b0;
    step();
    chk("ready_after_rst", 64'(rdy_w[i]), 64'd1);
    p_l = l0; p_r = r0; p_fmt = f0; p_mute = 1'b0; p_offer = 1'b1; p_late = 1'b0;
    apply_plan(i);
    ce_mode = mode;
    for (int k = 0; k < nfr; k++) begin
      ok = 1'b0;
      for (int c = 0; c < 4000 && !ok; c++) begin
        if (p_late && !sv[i] && nb[i] == 2 * sw) sv[i] = 1'b1;
        step();
        ok = fs_w[i];
      end
      chk("frame_start_seen", 64'(ok), 64'd1);
      if (!ok) return;
      if (p_late) begin
        sv[i] = 1'b0;
        chk("pass_through_ready", 64'(rdy_w[i]), 64'd1);
      end
      chk("underrun", 64'(ur_w[i]), 64'(!p_mute && !p_offer));
      if (have_prev) begin
        check_frame(i);
        if (mode == 1) chk("frame_period", 64'(tick - last_fs), 64'(4 * sw));
      end
      last_fs = tick;
      nb[i] = 0;
      m_sp = (!p_mute && m_fmt[1] == m_fmt[0]) ? m_r[0] : 1'b0;
      if (p_mute) begin m_l = '0; m_r = '0; end
      else if (p_offer) begin m_l = p_l; m_r = p_r; end
      m_fmt = p_fmt;
      have_prev = 1'b1;
      make_plan(i, k + 1, mode);
      apply_plan(i);
    end
  endtask

  initial begin
    run_seq(0, 8, 1, 2'd1, 16'h8001, 16'h7FFE);
    for (int c = 0; c < 1000 && nb[0] < 40; c++) step();
    chk("mid_frame_reached", 64'(nb[0] >= 40), 64'd1);
    run_seq(0, 3, 1, 2'd0, 16'h1234, 16'hABCD);
    run_seq(0, 6, 2, 2'd2, 16'($urandom), 16'($urandom));
    run_seq(1, 7, 1, 2'd0, 16'hC3A5, 16'h5A5B);
    run_seq(2, 6, 1, 2'd2, 16'hFFFF, 16'h0F0F);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
